bist_fault_tx: RTL
==================

# bist_fault_tx

Fault-report transmitter for the BIST side of the BIRA fault interface. It buffers fault records loaded by the test controller in a FIFO and replays them to the BIRA as one-cycle `fault_detect` pulses carrying row/col/bank/col_flag. Streaming ends with a one-cycle `test_end` pulse. A BIRA `early_term` aborts the stream and flushes the buffer. The block drives the BIRA fault inputs in both BIST emulation and bring-up benches.

## Interface
- `DEPTH`, 16: fault FIFO entries; power of two, minimum 2.
- `GAP`, 2: idle cycles between consecutive `fault_detect` pulses; 0 is legal and gives back-to-back pulses.
- `CW`, $clog2(DEPTH+1): width of `sent_count`.

- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-low reset.
- `load_valid` input 1: a fault record is offered on `load_data`.
- `load_data` input 30: record layout is {bank[29:28], row[27:18], col[17:8], col_flag[7:0]}.
- `load_ready` output 1: a record is accepted on a cycle where `load_valid && load_ready`.
- `start` input 1: begin streaming; sampled only in IDLE.
- `early_term` input 1: BIRA request to stop the test.
- `fault_detect` output 1: one-cycle fault strobe.
- `row_add_in` output 10: fault row address.
- `col_add_in` output 10: fault column address.
- `col_flag` output 8: fault column flag.
- `bank_in` output 2: fault bank.
- `test_end` output 1: one-cycle end-of-test strobe.
- `busy` output 1: high in every state except IDLE.
- `aborted` output 1: sticky flag; the last run was ended by `early_term`.
- `sent_count` output CW: number of faults emitted in the current or last run.

## Operation
- FIFO
  - Circular buffer with wrapping read and write pointers, plus an occupancy counter of width $clog2(DEPTH+1).
  - `load_ready` = (state == IDLE) && (occupancy < DEPTH). No loads are accepted while busy.
- FSM states: IDLE, SEND, GAP, END.
- IDLE
  - `start` with a non-empty FIFO: go to SEND. `sent_count` and `aborted` clear.
  - `start` with an empty FIFO: go to END. `sent_count` and `aborted` clear.
  - `early_term` is ignored.
- SEND (one cycle)
  - Pops the FIFO head onto the registered outputs and pulses `fault_detect`.
  - Increments `sent_count`.
  - Next state is GAP if GAP > 0.
  - If GAP == 0: next state is SEND when the FIFO is non-empty, otherwise END.
- GAP
  - A down-counter loaded with GAP-1 on entry.
  - At zero: go to SEND if the FIFO is non-empty, otherwise END.
- END (one cycle)
  - `test_end` = 1, then return to IDLE.
- Abort
  - `early_term` sampled high in SEND or GAP sends the FSM to END on the next edge.
  - `aborted` sets and the FIFO is flushed (pointers and occupancy go to 0).
  - The fault already being emitted in that SEND cycle still counts.
  - `early_term` on the edge that would start the next SEND: the abort wins and no further fault is emitted.
- `start` while busy is ignored.
- Address, flag and bank outputs hold their last emitted value between pulses.
- `sent_count` holds after END until the next accepted `start`.

## Timing
- Reset (asynchronous, `rst` = 0)
  - State goes to IDLE and the FIFO empties.
  - `fault_detect`, `test_end`, `busy`, `aborted` = 0; `sent_count` = 0.
  - `row_add_in`, `col_add_in`, `col_flag`, `bank_in` = 0; `load_ready` = 1.
- Reset mid-stream aborts silently: no `test_end` is generated.
- All outputs are registered except `load_ready`, which is decoded from state and occupancy.
- Latency
  - `start` sampled at edge k: the first `fault_detect` is high in cycle k+1.
  - Fault n (0-based) is high in cycle k+1+n·(GAP+1).
- `test_end` placement
  - Normal completion: `test_end` is high GAP+1 cycles after the last `fault_detect` cycle.
  - Empty start: `test_end` is high in cycle k+1.
  - Abort: `early_term` sampled at edge j gives `test_end` high in cycle j+1.
- `busy` is high from cycle k+1 through the `test_end` cycle inclusive.
- A load can be accepted on the same edge that `start` is accepted.
  - That record is included in the run.
  - `load_ready` drops in the next cycle.

## Test plan
- Reset: assert `rst`=0 mid-run.
  - Required: all outputs immediately take the reset values above, `load_ready`=1, and no `test_end` follows.
- Normal run: GAP=2, load records A, B, C, then `start` at edge 0.
  - Required: `fault_detect` in cycles 1, 4, 7 carrying A, B, C in order.
  - Required: `test_end` in cycle 10 and `sent_count`=3.
- Full FIFO: DEPTH=16, offer 17 records back-to-back.
  - Required: 16 accepted, `load_ready`=0 on the 17th.
  - Then `start`: 16 pulses in order, pointer wrap exercised.
- Abort: 5 records loaded, `early_term` pulsed during the GAP after the second fault.
  - Required: `test_end` the next cycle, `aborted`=1, `sent_count`=2.
  - Required: the FIFO is empty, and a subsequent `start` gives an immediate `test_end` with `sent_count`=0.
- Empty start and GAP=0 run:
  - Empty FIFO + `start`: `test_end` in cycle 1.
  - GAP=0 with 3 records: `fault_detect` in cycles 1, 2, 3 and `test_end` in cycle 4.
- Ignored inputs:
  - `start` and `load_valid` asserted while busy do not change the sequence.
  - `early_term` asserted in IDLE leaves `aborted`=0.

Source files
------------

// File: rtl/bist_fault_tx.sv
// Fault-report transmitter: buffers fault records in a FIFO and replays them to the
// BIRA as spaced one-cycle fault_detect strobes, closed by a one-cycle test_end strobe.
module bist_fault_tx #(
    parameter int DEPTH = 16,
    parameter int GAP   = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_valid,
    input  logic [29:0]   load_data,
    output logic          load_ready,
    input  logic          start,
    input  logic          early_term,
    output logic          fault_detect,
    output logic [9:0]    row_add_in,
    output logic [9:0]    col_add_in,
    output logic [7:0]    col_flag,
    output logic [1:0]    bank_in,
    output logic          test_end,
    output logic          busy,
    output logic          aborted,
    output logic [CW-1:0] sent_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int GW = (GAP < 2) ? 1 : $clog2(GAP);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_END  = 2'd3;

    typedef struct packed {
        logic [1:0] bank;
        logic [9:0] row;
        logic [9:0] col;
        logic [7:0] flag;
    } fault_rec_t;

    logic [1:0]    state, state_nx;
    fault_rec_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] occ;
    logic [GW-1:0] gap_cnt;
    logic          push, pop, flush, avail, start_acc;
    fault_rec_t    head;

    assign load_ready = (state == S_IDLE) && (occ < CW'(DEPTH));
    assign push       = load_valid && load_ready;
    assign start_acc  = (state == S_IDLE) && start;
    // A record loaded on the start edge into an empty FIFO is forwarded straight out.
    assign avail      = (occ != '0) || push;
    assign head       = (occ == '0) ? fault_rec_t'(load_data) : mem[rd_ptr];
    assign flush      = ((state == S_SEND) || (state == S_GAP)) && early_term;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = avail ? S_SEND : S_END;
            S_SEND: begin
                if (early_term)        state_nx = S_END;
                else if (GAP > 0)      state_nx = S_GAP;
                else if (occ != '0)    state_nx = S_SEND;
                else                   state_nx = S_END;
            end
            S_GAP: begin
                if (early_term)        state_nx = S_END;
                else if (gap_cnt == '0) state_nx = (occ != '0) ? S_SEND : S_END;
            end
            S_END:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // The pop happens on the edge entering SEND so the strobe and data are registered.
    assign pop = (state_nx == S_SEND);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= fault_rec_t'(load_data);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            gap_cnt      <= '0;
            fault_detect <= 1'b0;
            test_end     <= 1'b0;
            busy         <= 1'b0;
            aborted      <= 1'b0;
            sent_count   <= '0;
            row_add_in   <= '0;
            col_add_in   <= '0;
            col_flag     <= '0;
            bank_in      <= '0;
        end else begin
            state        <= state_nx;
            fault_detect <= pop;
            test_end     <= (state_nx == S_END);
            busy         <= (state_nx != S_IDLE);

            if (pop) begin
                row_add_in <= head.row;
                col_add_in <= head.col;
                col_flag   <= head.flag;
                bank_in    <= head.bank;
                sent_count <= start_acc ? CW'(1) : sent_count + CW'(1);
            end else if (start_acc) begin
                sent_count <= '0;
            end

            if (start_acc)  aborted <= 1'b0;
            else if (flush) aborted <= 1'b1;

            if (state == S_SEND && state_nx == S_GAP) gap_cnt <= GW'(GAP - 1);
            else if (state == S_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
        end
    end
endmodule
